cdb_broadcaster: RTL and testbench

//   Transmit side of the Common Data Bus (CDB) in the Tomasulo datapath.
//   - Accepts finished results from the functional units (ADD1, ADD2, ...).
//   - Buffers one result per unit and arbitrates round-robin.
//   - Drives one registered broadcast per cycle: Qi_CDB tag, Qi_CDB_data, and the
//     per-station R_enable / R_target strobes consumed by the register status

---
 rtl/cdb_broadcaster_pkg.sv | 21 ++
 rtl/cdb_broadcaster_rr_arbiter.sv | 32 +++
 rtl/cdb_broadcaster.sv | 129 ++++++++++++
 tb/tb_cdb_broadcaster.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_broadcaster_pkg.sv
// Shared CDB definitions: station tags, "no value" codes and datapath widths
// used by the broadcaster and its consumers in the Tomasulo datapath.
package cdb_broadcaster_pkg;

    localparam int DATA_W = 16;
    localparam int TGT_W  = 4;

    // Station tags as seen on Qi_CDB; tag 0 means no producing station.
    localparam logic [3:0] FREE_REGISTER    = 4'd0;
    localparam logic [3:0] RES_STATION_ADD1 = 4'd1;
    localparam logic [3:0] RES_STATION_ADD2 = 4'd2;

    localparam logic [DATA_W-1:0] Vj_Vk_sem_valor = 16'hFFF0;
    localparam logic [3:0]        Qj_Qk_sem_valor = 4'd0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_HELD  = 1'b1
    } slot_state_e;

endpackage : cdb_broadcaster_pkg

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Round-robin scan: grants the first requester found starting at ptr_i and
// wrapping modulo N. Purely combinational; the caller owns the pointer.
module rr_arbiter #(
    parameter int N     = 2,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic             valid_o,
    output logic [PTR_W-1:0] idx_o
);

    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so no path through the block can infer a latch.
    always_comb begin
        int j;
        grant_o = '0;
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        for (int i = 0; i < N; i++) begin
            j = (int'(ptr_i) + i) % N;
            if (!valid_o && req_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = PTR_W'(j);
            end
        end
    end

endmodule : rr_arbiter

// File: rtl/cdb_broadcaster.sv
// CDB transmit side: one hold slot per functional unit, round-robin
// arbitration, and a registered single broadcast per cycle.
module cdb_broadcaster #(
    parameter int                NUM_SRC   = 2,
    parameter int                DATA_W    = cdb_broadcaster_pkg::DATA_W,
    parameter int                TAG_W     = 4,
    parameter int                TGT_W     = cdb_broadcaster_pkg::TGT_W,
    parameter logic [DATA_W-1:0] IDLE_DATA = cdb_broadcaster_pkg::Vj_Vk_sem_valor
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic [NUM_SRC-1:0]         FU_valid,
    output logic [NUM_SRC-1:0]         FU_ready,
    input  logic [NUM_SRC*DATA_W-1:0]  FU_result,
    input  logic [NUM_SRC*TGT_W-1:0]   FU_target,
    output logic                       CDB_valid,
    output logic [TAG_W-1:0]           Qi_CDB,
    output logic [DATA_W-1:0]          Qi_CDB_data,
    output logic [NUM_SRC-1:0]         R_enable,
    output logic [TGT_W-1:0]           R_target
);

    import cdb_broadcaster_pkg::*;

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    slot_state_e         state_q  [NUM_SRC];
    logic [DATA_W-1:0]   result_q [NUM_SRC];
    logic [TGT_W-1:0]    target_q [NUM_SRC];

    logic [NUM_SRC-1:0]  held;
    logic [NUM_SRC-1:0]  grant;
    logic [NUM_SRC-1:0]  capture;
    logic                gnt_valid;
    logic [PTR_W-1:0]    gnt_idx;

    logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic                cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]    tag_q,       tag_d;
    logic [DATA_W-1:0]   data_q,      data_d;
    logic [NUM_SRC-1:0]  enable_q,    enable_d;
    logic [TGT_W-1:0]    tgt_q,       tgt_d;

    always_comb begin
        for (int k = 0; k < NUM_SRC; k++) begin
            held[k] = (state_q[k] == SLOT_HELD);
        end
    end

    // A slot draining onto the bus this cycle frees up at the same edge.
    assign FU_ready = ~held | grant;
    assign capture  = FU_valid & FU_ready;

    rr_arbiter #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_arb (
        .req_i   (held),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .valid_o (gnt_valid),
        .idx_o   (gnt_idx)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        tag_d       = TAG_W'(FREE_REGISTER);
        data_d      = IDLE_DATA;
        enable_d    = '0;
        tgt_d       = '0;
        if (gnt_valid) begin
            rr_ptr_d    = (gnt_idx == PTR_W'(NUM_SRC - 1)) ? '0 : gnt_idx + PTR_W'(1);
            cdb_valid_d = 1'b1;
            tag_d       = TAG_W'(gnt_idx) + TAG_W'(1);
            data_d      = result_q[gnt_idx];
            enable_d    = grant;
            tgt_d       = target_q[gnt_idx];
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NUM_SRC; k++) begin
                state_q[k] <= SLOT_EMPTY;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            tag_q       <= TAG_W'(Qj_Qk_sem_valor);
            data_q      <= IDLE_DATA;
            enable_q    <= '0;
            tgt_q       <= '0;
        end else begin
            for (int k = 0; k < NUM_SRC; k++) begin
                if (capture[k]) begin
                    state_q[k] <= SLOT_HELD;
                end else if (grant[k]) begin
                    state_q[k] <= SLOT_EMPTY;
                end
            end
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            enable_q    <= enable_d;
            tgt_q       <= tgt_d;
        end
    end

    // NOTE: slot payloads are not reset; they are only read while the slot
    // state says HELD, and the state itself is reset.
    always_ff @(posedge Clock) begin
        for (int k = 0; k < NUM_SRC; k++) begin
            if (capture[k]) begin
                result_q[k] <= FU_result[k*DATA_W +: DATA_W];
                target_q[k] <= FU_target[k*TGT_W +: TGT_W];
            end
        end
    end

    assign CDB_valid   = cdb_valid_q;
    assign Qi_CDB      = tag_q;
    assign Qi_CDB_data = data_q;
    assign R_enable    = enable_q;
    assign R_target    = tgt_q;

endmodule : cdb_broadcaster

// File: tb/tb_cdb_broadcaster.sv
// Self-checking bench for cdb_broadcaster: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_cdb_broadcaster;

    localparam int N  = 2;
    localparam int DW = 16;
    localparam int TW = 4;
    localparam int GW = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     fu_valid;
    logic [N-1:0]     fu_ready;
    logic [N*DW-1:0]  fu_result;
    logic [N*GW-1:0]  fu_target;
    logic             cdb_valid;
    logic [TW-1:0]    qi_cdb;
    logic [DW-1:0]    qi_cdb_data;
    logic [N-1:0]     r_enable;
    logic [GW-1:0]    r_target;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cdb_broadcaster #(
        .NUM_SRC   (N),
        .DATA_W    (DW),
        .TAG_W     (TW),
        .TGT_W     (GW),
        .IDLE_DATA (16'hFFF0)
    ) dut (
        .Clock       (clk),
        .Reset       (rst_n),
        .FU_valid    (fu_valid),
        .FU_ready    (fu_ready),
        .FU_result   (fu_result),
        .FU_target   (fu_target),
        .CDB_valid   (cdb_valid),
        .Qi_CDB      (qi_cdb),
        .Qi_CDB_data (qi_cdb_data),
        .R_enable    (r_enable),
        .R_target    (r_target)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each unit has at most one pending result; the bus picks the first pending
    // unit counting up from the unit after the last one served.
    bit            m_pend [N];
    logic [DW-1:0] m_data [N];
    logic [GW-1:0] m_tgt  [N];
    int            m_ptr;
    bit            e_valid;
    int            e_unit;
    logic [DW-1:0] e_data;
    logic [GW-1:0] e_tgt;

    function automatic int m_winner();
        for (int i = 0; i < N; i++) begin
            if (m_pend[(m_ptr + i) % N]) return (m_ptr + i) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int w;
        bit acc [N];
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_pend[k] = 1'b0;
            m_ptr   = 0;
            e_valid = 1'b0;
        end else begin
            w = m_winner();
            for (int k = 0; k < N; k++) acc[k] = fu_valid[k] && (!m_pend[k] || w == k);
            if (w >= 0) begin
                e_valid   = 1'b1;
                e_unit    = w;
                e_data    = m_data[w];
                e_tgt     = m_tgt[w];
                m_pend[w] = 1'b0;
                m_ptr     = (w + 1) % N;
            end else begin
                e_valid = 1'b0;
            end
            for (int k = 0; k < N; k++) begin
                if (acc[k]) begin
                    m_pend[k] = 1'b1;
                    m_data[k] = fu_result[k*DW +: DW];
                    m_tgt[k]  = fu_target[k*GW +: GW];
                end
            end
        end
    end

    // Single compare process, on the inactive clock edge.
    always @(negedge clk) begin
        logic [26:0] exp_bus;
        logic [N-1:0] exp_rdy;
        int w;
        if (e_valid)
            exp_bus = {1'b1, TW'(e_unit + 1), e_data, N'(1 << e_unit), e_tgt};
        else
            exp_bus = {1'b0, 4'd0, 16'hFFF0, 2'b00, 4'd0};
        check("model_bus", {cdb_valid, qi_cdb, qi_cdb_data, r_enable, r_target}, exp_bus);
        w = m_winner();
        for (int k = 0; k < N; k++) exp_rdy[k] = !m_pend[k] || (w == k);
        check("model_ready", fu_ready, exp_rdy);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_unit(input int k, input bit v, input logic [DW-1:0] d, input logic [GW-1:0] t);
        fu_valid[k]           = v;
        fu_result[k*DW +: DW] = d;
        fu_target[k*GW +: GW] = t;
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < N; k++) set_unit(k, 1'b0, '0, '0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_is(input string name, input bit v, input int tag, input logic [DW-1:0] d,
                          input logic [N-1:0] en, input logic [GW-1:0] t);
        check(name, {cdb_valid, qi_cdb, qi_cdb_data, r_enable, r_target}, {v, TW'(tag), d, en, t});
    endtask

    task automatic bus_idle(input string name);
        bus_is(name, 1'b0, 0, 16'hFFF0, '0, '0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        check("reset_ready", fu_ready, {N{1'b1}});
        bus_idle("reset_bus");
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int q_exp [N][$];
        int tags [$];
        int n_acc [N];
        int n_bc [N];
        int seq [N];
        int ones;
        bit acc [N];

        clear_inputs();
        tick();
        do_reset();

        // 1: reset asserted mid-stream discards held results.
        set_unit(0, 1'b1, 16'h0AAA, 4'd5);
        set_unit(1, 1'b1, 16'h0BBB, 4'd6);
        tick();
        clear_inputs();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        bus_idle("t1_async_bus");
        check("t1_async_ready", fu_ready, 2'b11);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            bus_idle("t1_post_release");
        end

        // 2: single ADD1 result.
        set_unit(0, 1'b1, 16'd7, 4'd2);
        tick();
        bus_idle("t2_capture_edge");
        clear_inputs();
        tick();
        bus_is("t2_bcast", 1'b1, 1, 16'd7, 2'b01, 4'd2);
        tick();
        bus_idle("t2_idle");

        // 3: both at once from rr_ptr=0.
        do_reset();
        set_unit(0, 1'b1, 16'd5, 4'd1);
        set_unit(1, 1'b1, 16'd9, 4'd3);
        tick();
        clear_inputs();
        tick();
        bus_is("t3_first", 1'b1, 1, 16'd5, 2'b01, 4'd1);
        tick();
        bus_is("t3_second", 1'b1, 2, 16'd9, 2'b10, 4'd3);
        tick();
        bus_idle("t3_idle");

        // 4: ADD1 streaming 1,2,3.
        for (int i = 1; i <= 3; i++) begin
            set_unit(0, 1'b1, 16'(i), 4'(i));
            check("t4_ready", fu_ready[0], 1'b1);
            tick();
            if (i > 1) bus_is("t4_stream", 1'b1, 1, 16'(i - 1), 2'b01, 4'(i - 1));
        end
        clear_inputs();
        check("t4_ready_last", fu_ready[0], 1'b1);
        tick();
        bus_is("t4_stream_last", 1'b1, 1, 16'd3, 2'b01, 4'd3);
        tick();
        bus_idle("t4_idle");

        // 5: both units continuously valid for 8 cycles.
        for (int k = 0; k < N; k++) begin
            seq[k]  = 100 * (k + 1);
            n_acc[k] = 0;
            n_bc[k]  = 0;
        end
        for (int c = 0; c < 11; c++) begin
            for (int k = 0; k < N; k++) begin
                if (c < 8) begin
                    set_unit(k, 1'b1, 16'(seq[k]), 4'(k));
                    if (fu_ready[k]) begin
                        q_exp[k].push_back(seq[k]);
                        n_acc[k]++;
                        seq[k]++;
                    end
                end else begin
                    set_unit(k, 1'b0, '0, '0);
                end
            end
            tick();
            if (cdb_valid) begin
                int u;
                u = int'(qi_cdb) - 1;
                tags.push_back(int'(qi_cdb));
                if (u >= 0 && u < N) begin
                    n_bc[u]++;
                    if (q_exp[u].size() == 0) check("t5_spurious", 1'b1, 1'b0);
                    else check("t5_order", qi_cdb_data, 16'(q_exp[u].pop_front()));
                end
            end
        end
        ones = 0;
        for (int i = 0; i < 8 && i < tags.size(); i++) begin
            if (tags[i] == 1) ones++;
            if (i > 0) check("t5_alternate", (tags[i] != tags[i-1]), 1'b1);
        end
        check("t5_first8_tag1", ones, 4);
        for (int k = 0; k < N; k++) check("t5_no_loss", n_bc[k], n_acc[k]);

        // 6: backpressure on ADD2 while ADD1 wins.
        do_reset();
        set_unit(0, 1'b1, 16'h0011, 4'd1);
        set_unit(1, 1'b1, 16'h0022, 4'd2);
        tick();
        check("t6_ready", fu_ready, 2'b01);
        set_unit(0, 1'b0, '0, '0);
        set_unit(1, 1'b1, 16'h0033, 4'd3);
        tick();
        bus_is("t6_add1", 1'b1, 1, 16'h0011, 2'b01, 4'd1);
        set_unit(1, 1'b0, '0, '0);
        tick();
        bus_is("t6_add2_orig", 1'b1, 2, 16'h0022, 2'b10, 4'd2);
        tick();
        bus_idle("t6_idle");

        // Randomized traffic at several densities, honouring the handshake.
        for (int k = 0; k < N; k++) acc[k] = 1'b0;
        for (int phase = 0; phase < 3; phase++) begin
            int density;
            density = (phase == 0) ? 30 : (phase == 1) ? 70 : 100;
            for (int c = 0; c < 600; c++) begin
                for (int k = 0; k < N; k++) begin
                    if (!fu_valid[k] || acc[k])
                        set_unit(k, ($urandom_range(0, 99) < density), 16'($urandom), 4'($urandom));
                    acc[k] = fu_valid[k] && fu_ready[k];
                end
                tick();
            end
        end
        clear_inputs();
        repeat (5) tick();
        bus_idle("drain_idle");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cdb_broadcaster
